pipe_credit_fifo: RTL and testbench



---
 rtl/pipe_credit_fifo_pkg.sv | 34 +++
 rtl/pipe_credit_fifo.sv | 97 +++++++++
 tb/tb_pipe_credit_fifo.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_credit_fifo_pkg.sv
// Shared sizing helpers for the credit FIFO: pointer/count widths, stall threshold
// and parameter-legality tests, all evaluated at elaboration time.
package pipe_credit_fifo_pkg;

    localparam int DEF_WIDTH        = 64;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_AFULL_MARGIN = 4;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so that a completely full buffer (count == depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int stall_thresh(input int depth, input int margin);
        return depth - margin;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit margin_ok(input int depth, input int margin);
        return (margin >= 1) && (margin < depth);
    endfunction

    localparam int PTR_W        = ptr_width(DEF_DEPTH);
    localparam int CNT_W        = cnt_width(DEF_DEPTH);
    localparam int STALL_THRESH = stall_thresh(DEF_DEPTH, DEF_AFULL_MARGIN);

endpackage

// File: rtl/pipe_credit_fifo.sv
// Elastic FWFT buffer behind a no-backpressure pipe: valid-only input, valid/ready
// output, early stall flag sized for upstream in-flight words, sticky loss flag.
module pipe_credit_fifo
    import pipe_credit_fifo_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int AFULL_MARGIN = DEF_AFULL_MARGIN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     stall_o,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(stall_thresh(DEPTH, AFULL_MARGIN));

    generate
        if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
            $error("pipe_credit_fifo: DEPTH must be a power of two and at least 4");
        end
        if (!margin_ok(DEPTH, AFULL_MARGIN)) begin : g_bad_margin
            $error("pipe_credit_fifo: AFULL_MARGIN must satisfy 1 <= AFULL_MARGIN < DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             overflow_reg;

    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic drop;

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    always_comb begin
        push       = valid_i;
        pop        = valid_o & ready_i;
        full       = (count_reg == FULL_CNT);
        wr_en      = push & (~full | pop);
        drop       = push & full & ~pop;
        count_next = count_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop && !wr_en) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    assign data_o     = mem[rd_ptr_reg];
    assign valid_o    = (count_reg != '0);
    assign stall_o    = (count_reg >= STALL_CNT);
    assign count_o    = count_reg;
    assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Randomized scoreboard bench for pipe_credit_fifo: a queue-based reference model
// is updated from observed stimulus and compared against the DUT every cycle.
module tb_pipe_credit_fifo;

    localparam int WIDTH  = 64;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             valid_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             ready_i = 1'b0;
    logic             stall_o;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic [4:0]       count_o;
    logic             overflow_o;

    pipe_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .stall_o    (stall_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model: contents of the buffer as a plain queue, plus the loss flag.
    logic [WIDTH-1:0] model_q [$];
    bit               model_ovf = 0;
    int               check_cnt = 0;
    int               pass_cnt  = 0;
    int               timeouts  = 0;
    int               pop_cnt   = 0;
    bit               have_prev = 0;
    logic [WIDTH-1:0] prev_data = '0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: samples on the falling edge, where outputs and next-edge inputs are both settled.
    always @(negedge clk) begin
        int  size;
        bit  pop;
        size = model_q.size();
        if (rst) begin
            chk("rst_valid", {63'd0, valid_o}, '0);
            chk("rst_count", {59'd0, count_o}, '0);
            chk("rst_stall", {63'd0, stall_o}, '0);
            chk("rst_ovf",   {63'd0, overflow_o}, '0);
            model_q.delete();
            model_ovf = 0;
            have_prev = 0;
        end else begin
            chk("valid", {63'd0, valid_o}, {63'd0, size != 0});
            chk("count", {59'd0, count_o}, WIDTH'(size));
            chk("stall", {63'd0, stall_o}, {63'd0, size >= DEPTH - MARGIN});
            chk("overflow", {63'd0, overflow_o}, {63'd0, model_ovf});
            if (size != 0) chk("data", data_o, model_q[0]);
            if (have_prev && valid_o) chk("stable", data_o, prev_data);
            pop       = (size != 0) && ready_i;
            have_prev = valid_o && !ready_i;
            prev_data = data_o;
            if (pop) begin
                pop_cnt++;
                $display("pop %0d data=%h count=%0d", pop_cnt, model_q[0], size);
                void'(model_q.pop_front());
            end
            if (valid_i) begin
                if (size < DEPTH || pop) model_q.push_back(data_i);
                else model_ovf = 1;
            end
        end
    end

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
        @(posedge clk);
        #2;
        valid_i = v;
        data_i  = d;
        ready_i = r;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 4 * DEPTH && !done; i++) begin
            step(1'b0, '0, 1'b1);
            if (!valid_o) done = 1;
        end
        if (!done) begin
            timeouts++;
            $display("FAIL drain_timeout: valid_o still %b", valid_o);
        end
        step(1'b0, '0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        valid_i = 1'b0;
        ready_i = 1'b0;
        rst     = 1'b1;
        #5;
        rst = 1'b0;
    endtask

    initial begin
        int  pushes;
        bit  seen;
        logic [WIDTH-1:0] k;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Single word with the consumer ready.
        step(1'b1, 64'hA5, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Fill to full, then push and pop together at full.
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(100 + i), 1'b0);
        step(1'b1, 64'h77, 1'b1);
        step(1'b0, '0, 1'b0);
        drain();

        // Fill, overflow with 99, drain, then rebuild 9 words and reset mid-stream.
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
        step(1'b1, 64'd99, 1'b0);
        step(1'b0, '0, 1'b0);
        drain();
        for (int i = 0; i < 9; i++) step(1'b1, WIDTH'(200 + i), 1'b0);
        step(1'b0, '0, 1'b0);
        pulse_reset();
        step(1'b1, 64'hC0FFEE, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Wrap-around: 40 random-gap pushes obeying stall, ready alternating.
        pushes = 0;
        for (int i = 0; i < 400 && pushes < 40; i++) begin
            bit v;
            v = ($urandom_range(0, 1) == 1) && !stall_o;
            step(v, WIDTH'(1000 + pushes), (i % 2) == 0);
            if (v) pushes++;
        end
        if (pushes < 40) begin
            timeouts++;
            $display("FAIL wrap_budget: pushes %0d required 40", pushes);
        end
        drain();

        // Stall contract: keep pushing for MARGIN cycles after stall is seen.
        seen = 0;
        k    = 0;
        for (int i = 0; i < 2 * DEPTH && !seen; i++) begin
            @(posedge clk);
            #2;
            if (stall_o) seen = 1;
            else begin
                valid_i = 1'b1;
                data_i  = k;
                ready_i = 1'b0;
                k++;
            end
        end
        if (!seen) begin
            timeouts++;
            $display("FAIL stall_timeout: stall_o never rose");
        end
        for (int i = 0; i < MARGIN - 1; i++) begin
            step(1'b1, k, 1'b0);
            k++;
        end
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        drain();

        // Unconstrained random soak, overflow allowed.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
        end
        drain();
        pulse_reset();
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt + timeouts);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
